stream_pump_split: RTL and testbench

// Slow-to-fast stream narrowing adapter for double-pumped datapaths. It accepts full-WIDTH

---
 rtl/stream_pump_split.sv | 82 ++++++++
 tb/tb_stream_pump_split.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pump_split.sv
// Slow-to-fast narrowing adapter: each slow-domain word is split into two half-width
// words on the clk2x stream, low half first, through a 4-entry half-word FIFO.
module stream_pump_split #(
    parameter int WIDTH = 16,
    localparam int HALF = (WIDTH + 1) / 2,
    localparam int SW   = ((WIDTH + 7) / 8) * 8,
    localparam int FW   = ((HALF + 7) / 8) * 8
) (
    input  logic          clk2x,
    input  logic          rst,
    output logic          s_axis_tready,
    input  logic          s_axis_tvalid,
    input  logic [SW-1:0] s_axis_tdata,
    input  logic          m_axis_tready,
    output logic          m_axis_tvalid,
    output logic [FW-1:0] m_axis_tdata
);
    localparam int DEPTH = 4;

    logic                       active_reg, active_next;
    logic [2:0]                 cnt_reg, cnt_next, cnt_popped;
    logic                       ready_reg, ready_next;
    logic [DEPTH-1:0][HALF-1:0] buf_reg, buf_next;
    logic [HALF-1:0]            lo_half, hi_half;
    logic                       pop, acc;
    logic                       unused_pad;

    assign unused_pad = ^{1'b0, s_axis_tdata};

    assign pop        = (cnt_reg != 3'd0) && m_axis_tready;
    assign acc        = active_reg && s_axis_tvalid && ready_reg;
    assign cnt_popped = cnt_reg - {2'b00, pop};
    assign cnt_next   = cnt_popped + (acc ? 3'd2 : 3'd0);
    assign active_next = ~active_reg;
    // Ready is only re-evaluated at slow edges so it stays flat across a slow cycle.
    assign ready_next = active_reg ? (cnt_next <= 3'd2) : ready_reg;

    always_comb begin
        lo_half = s_axis_tdata[HALF-1:0];
        hi_half = '0;
        hi_half[WIDTH-HALF-1:0] = s_axis_tdata[WIDTH-1:HALF];
    end

    // Per slot: shift down on pop, then the new pair lands just above the survivors.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [HALF-1:0] shifted;
            if (gi < DEPTH - 1) begin : g_mid
                assign shifted = pop ? buf_reg[gi+1] : buf_reg[gi];
            end else begin : g_top
                assign shifted = pop ? '0 : buf_reg[gi];
            end
            assign buf_next[gi] = (acc && (cnt_popped == 3'(gi)))          ? lo_half :
                                  (acc && ((cnt_popped + 3'd1) == 3'(gi))) ? hi_half :
                                  shifted;
        end
    endgenerate

    always_ff @(posedge clk2x) begin
        if (rst) begin
            active_reg <= 1'b0;
            cnt_reg    <= 3'd0;
            ready_reg  <= 1'b0;
            buf_reg    <= '0;
        end else begin
            active_reg <= active_next;
            cnt_reg    <= cnt_next;
            ready_reg  <= ready_next;
            buf_reg    <= buf_next;
        end
    end

    assign s_axis_tready = ready_reg;
    assign m_axis_tvalid = (cnt_reg != 3'd0);

    always_comb begin
        m_axis_tdata = '0;
        if (m_axis_tvalid) begin
            m_axis_tdata[HALF-1:0] = buf_reg[0];
        end
    end
endmodule

// File: tb/tb_stream_pump_split.sv
// Bench for stream_pump_split: queue-based reference of buffered halves, checked each
// clk2x cycle by a monitor; directed scenarios plus a long randomized run.
module tb_stream_pump_split;
    logic        clk2x = 1'b0;
    logic        rst = 1'b1;
    logic        s_ready, m_valid;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;

    logic        s9_ready, m9_valid;
    logic        s9_valid = 1'b0;
    logic [15:0] s9_data = '0;
    logic        m9_ready = 1'b1;
    logic [7:0]  m9_data;

    always #5 clk2x = ~clk2x;

    stream_pump_split #(.WIDTH(16)) dut (
        .clk2x(clk2x), .rst(rst),
        .s_axis_tready(s_ready), .s_axis_tvalid(s_valid), .s_axis_tdata(s_data),
        .m_axis_tready(m_ready), .m_axis_tvalid(m_valid), .m_axis_tdata(m_data)
    );

    stream_pump_split #(.WIDTH(9)) dut9 (
        .clk2x(clk2x), .rst(rst),
        .s_axis_tready(s9_ready), .s_axis_tvalid(s9_valid), .s_axis_tdata(s9_data),
        .m_axis_tready(m9_ready), .m_axis_tvalid(m9_valid), .m_axis_tdata(m9_data)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    bit model_active = 1'b0;
    bit model_ready = 1'b0;
    bit model_last_acc = 1'b0;
    bit mon_en = 1'b0;
    bit rand_mode = 1'b0;
    int acc_words = 0;
    int pops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor + reference: compares outputs mid-cycle, then applies the coming edge's
    // pop (scoreboard pop) and accept (scoreboard push of lo, hi).
    always @(negedge clk2x) begin
        if (mon_en) begin
            check("m_tvalid", {31'd0, m_valid}, {31'd0, exp_q.size() != 0});
            check("s_tready", {31'd0, s_ready}, {31'd0, model_ready});
            if (exp_q.size() != 0) check("m_tdata", {24'd0, m_data}, {24'd0, exp_q[0]});
            if (rst) begin
                exp_q.delete();
                model_ready = 1'b0;
                model_active = 1'b0;
                model_last_acc = 1'b0;
            end else begin
                if (exp_q.size() != 0 && m_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
                model_last_acc = model_active && s_valid && model_ready;
                if (model_last_acc) begin
                    exp_q.push_back(s_data[7:0]);
                    exp_q.push_back(s_data[15:8]);
                    acc_words++;
                    $display("accept #%0d word=0x%04h t=%0t", acc_words, s_data, $time);
                end
                if (model_active) model_ready = (exp_q.size() <= 2);
                model_active = !model_active;
            end
        end
    end

    always @(posedge clk2x) begin
        if (rand_mode) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Returns just after the next slow (Active) edge.
    task automatic slow_step();
        do begin
            @(posedge clk2x);
            #1;
        end while (model_active);
    endtask

    task automatic send_word(input logic [15:0] d);
        int n;
        s_valid = 1'b1;
        s_data = d;
        n = 0;
        do begin
            slow_step();
            n++;
        end while (!model_last_acc && n < 50);
        check("send_accept", {31'd0, model_last_acc}, 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk2x);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        slow_step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got[$];
        int first_i;
        int sent;
        int iter;
        int pops_before;

        repeat (4) @(posedge clk2x);
        #1;
        mon_en = 1'b1;
        check("rst_m_tvalid", {31'd0, m_valid}, 32'd0);
        check("rst_s_tready", {31'd0, s_ready}, 32'd0);
        check("rst_m_tdata", {24'd0, m_data}, 32'd0);
        check("rst_s9_tready", {31'd0, s9_ready}, 32'd0);
        rst = 1'b0;
        slow_step();

        // WIDTH=9 split of 0x1A5: 0x05 then 0x0D, back to back
        check("t1_s9_ready", {31'd0, s9_ready}, 32'd1);
        s9_valid = 1'b1;
        s9_data = 16'h01A5;
        slow_step();
        s9_valid = 1'b0;
        first_i = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk2x);
            if (m9_valid) begin
                if (first_i < 0) first_i = i;
                got.push_back(m9_data);
            end
        end
        check("t1_valid_cycles", got.size(), 32'd2);
        check("t1_latency", first_i, 32'd0);
        if (got.size() >= 2) begin
            check("t1_lo", {24'd0, got[0]}, 32'h05);
            check("t1_hi", {24'd0, got[1]}, 32'h0D);
        end
        slow_step();

        // back-to-back words with the fast side always ready
        m_ready = 1'b1;
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        wait_drain();

        // stall fast side: two words fill the buffer, ready drops, head holds
        m_ready = 1'b0;
        send_word(16'hAAAA);
        send_word(16'hBBBB);
        check("t3_s_tready", {31'd0, s_ready}, 32'd0);
        check("t3_head", {24'd0, m_data}, 32'hAA);
        slow_step();
        slow_step();
        check("t3_head_hold", {24'd0, m_data}, 32'hAA);
        check("t3_valid_hold", {31'd0, m_valid}, 32'd1);
        m_ready = 1'b1;
        wait_drain();

        // valid pulsed only across a non-Active edge must not be taken
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1;
            s_data = 16'hDEAD;
            @(posedge clk2x);
            #1;
            s_valid = 1'b0;
            slow_step();
            check("t6_no_accept", {31'd0, m_valid}, 32'd0);
        end

        // reset with three halves buffered
        m_ready = 1'b0;
        send_word(16'h6251);
        send_word(16'h8473);
        m_ready = 1'b1;
        @(posedge clk2x);
        #1;
        m_ready = 1'b0;
        @(posedge clk2x);
        #1;
        check("t5_head", {24'd0, m_data}, 32'h62);
        rst = 1'b1;
        @(posedge clk2x);
        #1;
        check("t5_rst_valid", {31'd0, m_valid}, 32'd0);
        check("t5_rst_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk2x);
        #1;
        rst = 1'b0;
        slow_step();
        m_ready = 1'b1;
        pops_before = pops;
        send_word(16'h1234);
        check("t5_first_lo", {24'd0, m_data}, 32'h34);
        wait_drain();
        check("t5_pop_count", pops - pops_before, 32'd2);

        // randomized traffic with 50% fast-side ready
        rand_mode = 1'b1;
        sent = 0;
        iter = 0;
        while (sent < 1000 && iter < 20000) begin
            if (!s_valid && $urandom_range(0, 3) != 0) begin
                s_valid = 1'b1;
                s_data = 16'($urandom);
            end
            slow_step();
            if (s_valid && model_last_acc) begin
                sent++;
                s_valid = 1'b0;
            end
            iter++;
        end
        check("t4_words_sent", sent, 32'd1000);
        s_valid = 1'b0;
        rand_mode = 1'b0;
        @(posedge clk2x);
        #2;
        m_ready = 1'b1;
        wait_drain();
        check("end_m_tvalid", {31'd0, m_valid}, 32'd0);
        check("end_s_tready", {31'd0, s_ready}, 32'd1);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
